// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide scheduler: operation codes,
// FSM states and default latencies.
package md_ctrl_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_MULT  = 3'd0;
    localparam md_op_t MD_MULTU = 3'd1;
    localparam md_op_t MD_DIV   = 3'd2;
    localparam md_op_t MD_DIVU  = 3'd3;
    localparam md_op_t MD_MTHI  = 3'd4;
    localparam md_op_t MD_MTLO  = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    // Operations that occupy the unit for several cycles.
    function automatic logic is_long_op(input md_op_t op);
        return (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {HI,LO} result for mult/multu/div/divu, plus a flag
// telling the controller that a divide has a zero divisor.
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        divzero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               signed_div;
    logic        [31:0] abs_a;
    logic        [31:0] abs_b;
    logic        [31:0] div_b;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic        [31:0] quot;
    logic        [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000 survives as an unsigned
    // magnitude, so the -2^31 / -1 case falls out without special handling.
    assign signed_div = (op == MD_DIV);
    assign abs_a      = (signed_div && a[31]) ? -a : a;
    assign abs_b      = (signed_div && b[31]) ? -b : b;
    assign div_b      = (b == 32'd0) ? 32'd1 : abs_b;
    assign uq         = abs_a / div_b;
    assign ur         = abs_a % div_b;
    assign quot       = (signed_div && (a[31] ^ b[31])) ? -uq : uq;
    assign rem        = (signed_div && a[31]) ? -ur : ur;

    assign divzero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:         result = prod_s;
            MD_MULTU:        result = prod_u;
            MD_DIV, MD_DIVU: result = {rem, quot};
            default:         result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide scheduler: latency countdown, HI/LO ownership and
// D-stage stall. Define MD_ABORT_EN to add the exception-flush abort input.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
`ifdef MD_ABORT_EN
    input  logic        abort,
`endif
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_isdm,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [3:0] MUL_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    logic [1:0]  state_reg;
    logic [3:0]  count_reg;
    logic [2:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;
    logic        abort_act;
    logic        start_ok;
    logic [63:0] arith_result;
    logic        arith_divzero;

`ifdef MD_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif
    assign start_ok = start & ~abort_act;

    md_arith u_arith (
        .op      (op_reg),
        .a       (a_reg),
        .b       (b_reg),
        .result  (arith_result),
        .divzero (arith_divzero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            count_reg <= 4'd0;
            op_reg    <= 3'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                state_reg <= S_MUL;
                                count_reg <= MUL_CNT;
                                op_reg    <= md_op;
                                a_reg     <= rs_val;
                                b_reg     <= rt_val;
                            end
                            MD_DIV, MD_DIVU: begin
                                state_reg <= S_DIV;
                                count_reg <= DIV_CNT;
                                op_reg    <= md_op;
                                a_reg     <= rs_val;
                                b_reg     <= rt_val;
                            end
                            MD_MTHI: hi_reg <= rs_val;
                            MD_MTLO: lo_reg <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (abort_act) begin
                        state_reg <= S_IDLE;
                        count_reg <= 4'd0;
                    end else if (count_reg == 4'd1) begin
                        // A zero divisor still finishes and pulses done, but leaves HI/LO alone.
                        if (!arith_divzero) begin
                            hi_reg <= arith_result[63:32];
                            lo_reg <= arith_result[31:0];
                        end
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                        count_reg <= 4'd0;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    count_reg <= 4'd0;
                end
            endcase
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign stall  = d_isdm & (busy | (start & is_long_op(md_op)));
    assign done   = done_reg;
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

endmodule
